// File: rtl/mem_pkg.sv
// mem_pkg: state encoding and widths shared by the data-memory controller and its users.
package mem_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int MEM_ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ERR_RDATA = 16'h0000;
endpackage

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage controller running one req/ack data-memory transaction per LW/SW,
// stalling the core until it completes and flagging misalignment, conflicting controls and ack timeout.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [15:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     rdata_out,
  output logic                  rdata_valid,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  request, legal;
  assign request = mem_read | mem_write;
  assign legal = (mem_read ^ mem_write) & ~addr[0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    if (state_q == ST_IDLE) begin
      if (request && legal) begin
        we_d = mem_write;
        maddr_d = addr[15:1];
        wdata_d = wdata;
        cnt_d = '0;
        state_d = ST_REQ;
      end else if (request) begin
        err_d = 1'b1;
        rdata_d = ERR_RDATA;
        state_d = ST_DONE;
      end
    end else if (state_q == ST_REQ) begin
      if (mem_ack) begin
        rdata_d = we_q ? rdata_q : mem_rdata;
        state_d = ST_DONE;
      end else if (cnt_q == CNT_LAST) begin
        err_d = 1'b1;
        rdata_d = ERR_RDATA;
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= ERR_RDATA;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // mem_req decodes straight from state so an async reset drops it without waiting for a clock
  assign mem_req = state_q == ST_REQ;
  assign stall = (state_q == ST_IDLE && request) || state_q == ST_REQ;
  assign rdata_valid = state_q == ST_DONE;
  assign rdata_out = rdata_q;
  assign err = err_q;
  assign mem_we = we_q;
  assign mem_addr = maddr_q;
  assign mem_wdata = wdata_q;
endmodule
